// File: rtl/inst_fetch_pkg.sv
// rtl/inst_fetch_pkg.sv - shared constants and state encoding for the instruction-fetch stage
package inst_fetch_pkg;

    localparam logic [31:0] ZeroWord     = 32'h0000_0000;
    localparam logic        Stop         = 1'b1;
    localparam logic        NoStop       = 1'b0;
    localparam logic [31:0] RESET_PC_VAL = 32'hBFC0_0000;

    // Bit of the pipeline stall vector that tells IF/ID not to load.
    localparam int          STALL_IFID_BIT = 1;

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_DATA = 2'd1,
        S_HOLD = 2'd2
    } if_state_e;

    // Sequential successor of a PC; wraps at 32 bits, no alignment check.
    function automatic logic [31:0] seq_pc(input logic [31:0] pc);
        return pc + 32'd4;
    endfunction

endpackage

// File: rtl/inst_fetch.sv
// rtl/inst_fetch.sv - IF stage: owns the PC, one outstanding fetch, holds the word for IF/ID
module inst_fetch
    import inst_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_VAL
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [5:0]  stall,
    input  logic        flush,
    input  logic [31:0] flush_pc,
    input  logic        branch_flag,
    input  logic [31:0] branch_target,
    output logic        inst_req,
    output logic [31:0] inst_addr,
    input  logic        inst_addr_ok,
    input  logic        inst_data_ok,
    input  logic [31:0] inst_rdata,
    output logic [31:0] o_pc,
    output logic [31:0] o_inst,
    output logic        stallreq_if
);

    if_state_e   state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic        cancel_q, cancel_d;
    logic        branch_pending_q, branch_pending_d;
    logic [31:0] pend_target_q, pend_target_d;
    logic [31:0] buf_q, buf_d;

    logic        ifid_stop;
    logic        holding;

    // Only the IF/ID bit of the stall vector matters to this stage.
    logic        unused_stall_bits;
    assign unused_stall_bits = ^{stall[5:2], stall[0]};

    assign ifid_stop = (stall[STALL_IFID_BIT] == Stop);

    // Outputs come from registered state only; reset masks them so nothing leaks during reset.
    assign holding     = !reset && (state_q == S_HOLD);
    assign inst_req    = !reset && (state_q == S_REQ);
    assign inst_addr   = pc_q;
    assign o_pc        = holding ? pc_q  : ZeroWord;
    assign o_inst      = holding ? buf_q : ZeroWord;
    assign stallreq_if = !holding;

    // Next-state logic: fetch handshake, delay-slot branch tracking and flush redirect.
    always_comb begin
        state_d          = state_q;
        pc_d             = pc_q;
        cancel_d         = cancel_q;
        branch_pending_d = branch_pending_q;
        pend_target_d    = pend_target_q;
        buf_d            = buf_q;

        // A branch resolved in ID is remembered until the delay slot leaves this stage.
        if (!flush && branch_flag) begin
            branch_pending_d = 1'b1;
            pend_target_d    = branch_target;
        end

        case (state_q)
            S_REQ: begin
                if (flush) begin
                    pc_d             = flush_pc;
                    branch_pending_d = 1'b0;
                    if (inst_addr_ok) begin
                        // The accepted request was for the squashed PC; its data must be dropped.
                        state_d  = S_DATA;
                        cancel_d = 1'b1;
                    end
                end else if (inst_addr_ok) begin
                    state_d = S_DATA;
                end
            end

            S_DATA: begin
                if (flush) begin
                    pc_d             = flush_pc;
                    branch_pending_d = 1'b0;
                end
                if (inst_data_ok) begin
                    if (cancel_q || flush) begin
                        cancel_d = 1'b0;
                        state_d  = S_REQ;
                    end else begin
                        buf_d   = inst_rdata;
                        state_d = S_HOLD;
                    end
                end else if (flush) begin
                    cancel_d = 1'b1;
                end
            end

            S_HOLD: begin
                if (flush) begin
                    pc_d             = flush_pc;
                    branch_pending_d = 1'b0;
                    buf_d            = ZeroWord;
                    state_d          = S_REQ;
                end else if (!ifid_stop) begin
                    // The held word is the delay slot when a branch is pending or arrives now.
                    if (branch_flag) begin
                        pc_d = branch_target;
                    end else if (branch_pending_q) begin
                        pc_d = pend_target_q;
                    end else begin
                        pc_d = seq_pc(pc_q);
                    end
                    branch_pending_d = 1'b0;
                    state_d          = S_REQ;
                end
            end

            default: begin
                state_d = S_REQ;
            end
        endcase
    end

    // State registers with synchronous active-high reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q          <= S_REQ;
            pc_q             <= RESET_PC;
            cancel_q         <= 1'b0;
            branch_pending_q <= 1'b0;
            pend_target_q    <= ZeroWord;
            buf_q            <= ZeroWord;
        end else begin
            state_q          <= state_d;
            pc_q             <= pc_d;
            cancel_q         <= cancel_d;
            branch_pending_q <= branch_pending_d;
            pend_target_q    <= pend_target_d;
            buf_q            <= buf_d;
        end
    end

endmodule

// File: tb/tb_inst_fetch.sv
// tb/tb_inst_fetch.sv - directed self-checking bench for the instruction-fetch stage
module tb_inst_fetch;

    logic        clk;
    logic        reset;
    logic [5:0]  stall;
    logic        flush;
    logic [31:0] flush_pc;
    logic        branch_flag;
    logic [31:0] branch_target;
    logic        inst_req;
    logic [31:0] inst_addr;
    logic        inst_addr_ok;
    logic        inst_data_ok;
    logic [31:0] inst_rdata;
    logic [31:0] o_pc;
    logic [31:0] o_inst;
    logic        stallreq_if;

    int checks;
    int failures;

    inst_fetch dut (
        .clk           (clk),
        .reset         (reset),
        .stall         (stall),
        .flush         (flush),
        .flush_pc      (flush_pc),
        .branch_flag   (branch_flag),
        .branch_target (branch_target),
        .inst_req      (inst_req),
        .inst_addr     (inst_addr),
        .inst_addr_ok  (inst_addr_ok),
        .inst_data_ok  (inst_data_ok),
        .inst_rdata    (inst_rdata),
        .o_pc          (o_pc),
        .o_inst        (o_inst),
        .stallreq_if   (stallreq_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One complete zero-wait fetch starting at a negedge where the DUT is in S_REQ.
    task automatic fetch_one(input logic [31:0] addr, input logic [31:0] word,
                             input int stall_cycles, input logic do_branch,
                             input logic [31:0] tgt);
        check("req_valid", {31'b0, inst_req}, 32'd1);
        check("req_addr", inst_addr, addr);
        check("req_stallreq", {31'b0, stallreq_if}, 32'd1);
        check("req_o_pc", o_pc, 32'h0);
        inst_addr_ok = 1'b1;
        @(negedge clk);
        inst_addr_ok = 1'b0;
        check("data_req", {31'b0, inst_req}, 32'd0);
        check("data_o_inst", o_inst, 32'h0);
        check("data_stallreq", {31'b0, stallreq_if}, 32'd1);
        inst_data_ok = 1'b1;
        inst_rdata   = word;
        if (do_branch) begin
            branch_flag   = 1'b1;
            branch_target = tgt;
        end
        @(negedge clk);
        inst_data_ok = 1'b0;
        branch_flag  = 1'b0;
        check("hold_stallreq", {31'b0, stallreq_if}, 32'd0);
        check("hold_o_pc", o_pc, addr);
        check("hold_o_inst", o_inst, word);
        check("hold_req", {31'b0, inst_req}, 32'd0);
        for (int i = 0; i < stall_cycles; i++) begin
            stall = 6'b000010;
            @(negedge clk);
            check("stall_o_pc", o_pc, addr);
            check("stall_o_inst", o_inst, word);
            check("stall_stallreq", {31'b0, stallreq_if}, 32'd0);
            check("stall_req", {31'b0, inst_req}, 32'd0);
        end
        stall = 6'b000000;
        @(negedge clk);
    endtask

    initial begin
        checks        = 0;
        failures      = 0;
        reset         = 1'b1;
        stall         = 6'b0;
        flush         = 1'b0;
        flush_pc      = 32'h0;
        branch_flag   = 1'b0;
        branch_target = 32'h0;
        inst_addr_ok  = 1'b0;
        inst_data_ok  = 1'b0;
        inst_rdata    = 32'h0;

        // Reset outputs
        @(negedge clk);
        check("rst_req", {31'b0, inst_req}, 32'd0);
        check("rst_o_pc", o_pc, 32'h0);
        check("rst_o_inst", o_inst, 32'h0);
        check("rst_stallreq", {31'b0, stallreq_if}, 32'd1);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        // Sequential fetch, zero-wait bus
        fetch_one(32'hBFC0_0000, 32'h2401_0001, 0, 1'b0, 32'h0);
        fetch_one(32'hBFC0_0004, 32'h2402_0002, 0, 1'b0, 32'h0);
        fetch_one(32'hBFC0_0008, 32'h2403_0003, 0, 1'b0, 32'h0);

        // Branch in S_DATA of the delay slot
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        fetch_one(32'hBFC0_0000, 32'h1000_0040, 0, 1'b0, 32'h0);
        fetch_one(32'hBFC0_0004, 32'h0000_0000, 0, 1'b1, 32'h8000_0100);
        fetch_one(32'h8000_0100, 32'h3C08_1234, 0, 1'b0, 32'h0);

        // Flush in S_DATA, stale data two cycles later
        check("fl_req_addr", inst_addr, 32'h8000_0104);
        inst_addr_ok = 1'b1;
        @(negedge clk);
        inst_addr_ok = 1'b0;
        flush        = 1'b1;
        flush_pc     = 32'hBFC0_0380;
        @(negedge clk);
        flush = 1'b0;
        check("fl_wait_req", {31'b0, inst_req}, 32'd0);
        check("fl_wait_stallreq", {31'b0, stallreq_if}, 32'd1);
        @(negedge clk);
        check("fl_wait2_req", {31'b0, inst_req}, 32'd0);
        inst_data_ok = 1'b1;
        inst_rdata   = 32'hDEAD_BEEF;
        @(negedge clk);
        inst_data_ok = 1'b0;
        check("fl_drop_o_inst", o_inst, 32'h0);
        check("fl_drop_stallreq", {31'b0, stallreq_if}, 32'd1);
        fetch_one(32'hBFC0_0380, 32'h4000_6800, 0, 1'b0, 32'h0);

        // Hold with IF/ID stopped for 4 cycles
        fetch_one(32'hBFC0_0384, 32'h0123_4567, 4, 1'b0, 32'h0);

        // Flush and branch in the same cycle
        check("fb_req_addr", inst_addr, 32'hBFC0_0388);
        flush         = 1'b1;
        flush_pc      = 32'hBFC0_0200;
        branch_flag   = 1'b1;
        branch_target = 32'h8000_0000;
        @(negedge clk);
        flush       = 1'b0;
        branch_flag = 1'b0;
        fetch_one(32'hBFC0_0200, 32'h0000_000C, 0, 1'b0, 32'h0);
        fetch_one(32'hBFC0_0204, 32'h0000_000D, 0, 1'b0, 32'h0);

        // Reset while in S_DATA with a stale response during reset
        check("rd_req_addr", inst_addr, 32'hBFC0_0208);
        inst_addr_ok = 1'b1;
        @(negedge clk);
        inst_addr_ok = 1'b0;
        reset        = 1'b1;
        inst_data_ok = 1'b1;
        inst_rdata   = 32'hCAFE_F00D;
        @(negedge clk);
        inst_data_ok = 1'b0;
        check("rd_rst_req", {31'b0, inst_req}, 32'd0);
        check("rd_rst_o_inst", o_inst, 32'h0);
        check("rd_rst_stallreq", {31'b0, stallreq_if}, 32'd1);
        reset = 1'b0;
        @(negedge clk);
        check("rd_after_o_inst", o_inst, 32'h0);
        fetch_one(32'hBFC0_0000, 32'h3408_0001, 0, 1'b0, 32'h0);

        // Flush in S_REQ in the same cycle as addr_ok
        check("fa_req_addr", inst_addr, 32'hBFC0_0004);
        inst_addr_ok = 1'b1;
        flush        = 1'b1;
        flush_pc     = 32'hBFC0_0100;
        @(negedge clk);
        inst_addr_ok = 1'b0;
        flush        = 1'b0;
        check("fa_data_req", {31'b0, inst_req}, 32'd0);
        inst_data_ok = 1'b1;
        inst_rdata   = 32'h1111_1111;
        @(negedge clk);
        inst_data_ok = 1'b0;
        check("fa_drop_o_inst", o_inst, 32'h0);
        fetch_one(32'hBFC0_0100, 32'h2222_2222, 0, 1'b0, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
